usb_rx_unstuff_crc: RTL and testbench
=====================================

// Module: usb_rx_unstuff_crc
// PURPOSE
// USB receive back-end after NRZI decode: removes stuffed bits, checks the PID, captures the payload and verifies the data CRC16.
// Takes the serial, NRZI-decoded bit stream and presents the parallel PID/data plus a status flag that the protocol FSM acknowledges.
// Covers the bitUnstuffer -> bs_decoder -> rc_crc chain as one block.
// PARAMETERS
// DATA_BITS    64        payload bits per data packet
// CRC_RESIDUE  16'h800D  CRC16 residual of a good packet (register state after data+CRC bits, before final inversion)
// PORTS
// clk              input   1   system clock, all logic on rising edge
// rst_n            input   1   asynchronous reset, ACTIVE-HIGH (1 = reset) despite the legacy name
// s_in             input   1   NRZI-decoded serial bit, one per clock
// start_unstuffer  input   1   one-cycle pulse the cycle BEFORE the first PID bit; s_in on that cycle is ignored
// end_unstuffer    input   1   one-cycle pulse coincident with the last packet bit; that bit is sampled
// pkt_rec          input   1   one-cycle acknowledge from consumer; returns pkt_status to PROCESSING
// pkt_status       output  1   0 = PROCESSING, 1 = RECEIVED (packet outputs valid)
// rc_hshake        output  8   received PID byte, first wire bit in [7]
// rc_data          output  64  payload, first payload bit in [63]
// PID_error        output  1   PID check nibble mismatch
// rc_CRCerror      output  1   CRC residual mismatch or bit-stuff violation
// BEHAVIOUR
// - Reset: all outputs 0, every FSM in IDLE, ones counter 0, CRC register 16'hFFFF.
// - Unstuffer FSM IDLE/ACTIVE: start -> ACTIVE, ones count cleared; each ACTIVE cycle samples s_in.
//   After six consecutive 1s the next bit is dropped (count cleared); if that bit is 1, set stuff violation.
//   Non-dropped bits forwarded with a valid strobe, 1-cycle latency; end_unstuffer -> IDLE after its bit.
// - Decoder FSM IDLE/PID/DATA/DONE: first 8 forwarded bits shift into rc_hshake MSB-first.
//   PID_error = (rc_hshake[7:4] != ~rc_hshake[3:0]), set at 8th bit, held till next start.
//   Remaining bits forwarded to CRC stage; bits after 64+16 are ignored.
// - CRC stage: payload bits shift into rc_data MSB-first (bits 1..64 after PID); x^16+x^15+x^2+1,
//   init 16'hFFFF, updated on payload AND 16 CRC bits; rc_CRCerror = (reg != CRC_RESIDUE) | stuff violation.
// - Packet of exactly 8 bits (handshake): no CRC check, rc_data held at 0, rc_CRCerror = stuff violation only.
// - Data packet shorter than 88 bits at end: rc_CRCerror = 1.
// - pkt_status rises 3 clocks after the edge sampling the end bit; rc_hshake/rc_data/errors stable from then.
// - pkt_status stays 1 until pkt_rec pulse (-> 0 next edge); pkt_rec while 0 ignored.
// - start while RECEIVED or mid-packet: abort, clear status/errors/rc_data/CRC, begin new packet.
// - end on a cycle holding a stuffed bit: bit dropped, packet still closes.
// - end with no start: ignored. Reset mid-packet: immediate return to reset state.
// TESTING
// - Stuffed 89-bit stream 11000011 1111011101111101101101010111101101111101010111010111111 0 1010100111101101111000101
//   -> pkt_status=1, rc_hshake=8'hC3, rc_data=64'hF77DB57B7D5D7F53, PID_error=0.
// - Same packet with a valid CRC16 appended -> rc_CRCerror=0; flip one payload bit -> rc_CRCerror=1.
// - PID 8'b11000010 -> PID_error=1; handshake only 8'hD2 (8 bits) -> pkt_status=1, rc_CRCerror=0, rc_data=0.
// - Seven consecutive 1s inside payload -> rc_CRCerror=1.
// - RECEIVED held 5 cycles, pkt_rec pulse -> pkt_status=0 next edge; second packet decodes correctly.
// - Reset asserted mid-packet -> all outputs 0; next packet decodes normally.

Source files
------------

// File: rtl/usb_rx_unstuff_crc.sv
// USB receive back-end: removes stuffed bits from the NRZI-decoded stream, captures and checks
// the PID, shifts in the payload and verifies the CRC16 residual, then flags the packet as received.
module usb_rx_unstuff_crc #(
  parameter int unsigned DATA_BITS   = 64,
  parameter logic [15:0] CRC_RESIDUE = 16'h800D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_in,
  input  logic                 start_unstuffer,
  input  logic                 end_unstuffer,
  input  logic                 pkt_rec,
  output logic                 pkt_status,
  output logic [7:0]           rc_hshake,
  output logic [DATA_BITS-1:0] rc_data,
  output logic                 PID_error,
  output logic                 rc_CRCerror
);

  localparam int unsigned PID_BITS = 8;
  localparam int unsigned CRC_BITS = 16;
  localparam int unsigned PKT_BITS = PID_BITS + DATA_BITS + CRC_BITS;
  localparam int unsigned CW       = $clog2(PKT_BITS + 1);

  localparam logic [CW-1:0] CNT_PID_LAST = CW'(PID_BITS - 1);
  localparam logic [CW-1:0] CNT_HSHAKE   = CW'(PID_BITS);
  localparam logic [CW-1:0] CNT_PAY_END  = CW'(PID_BITS + DATA_BITS);
  localparam logic [CW-1:0] CNT_PKT_END  = CW'(PKT_BITS);
  localparam logic [15:0]   CRC_POLY     = 16'h8005;

  typedef enum logic {US_IDLE, US_ACTIVE} us_state_t;
  typedef enum logic [1:0] {DEC_IDLE, DEC_PID, DEC_DATA, DEC_DONE} dec_state_t;

  // unstuffer -> decoder
  us_state_t  us_state;
  logic [2:0] ones_cnt;
  logic [3:0] pid_left;
  logic       stuff_viol;
  logic       ub_valid;
  logic       ub_bit;
  logic       ub_last;

  // decoder -> CRC stage
  dec_state_t    dec_state;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    pid_next;
  logic          fw_valid;
  logic          fw_bit;
  logic          fw_payload;
  logic          dec_last;

  // CRC stage -> status
  logic [15:0] crc;
  logic        crc_last;
  logic        crc_fail;

  // The PID byte is passed straight through; the ones run that governs unstuffing starts
  // with the first payload bit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      us_state   <= US_IDLE;
      ones_cnt   <= '0;
      pid_left   <= '0;
      stuff_viol <= 1'b0;
      ub_valid   <= 1'b0;
      ub_bit     <= 1'b0;
      ub_last    <= 1'b0;
    end else begin
      ub_valid <= 1'b0;
      ub_last  <= 1'b0;
      if (start_unstuffer) begin
        us_state   <= US_ACTIVE;
        ones_cnt   <= '0;
        pid_left   <= 4'd8;
        stuff_viol <= 1'b0;
      end else if (us_state == US_ACTIVE) begin
        if (pid_left != '0) begin
          ub_valid <= 1'b1;
          ub_bit   <= s_in;
          pid_left <= pid_left - 4'd1;
        end else if (ones_cnt == 3'd6) begin
          ones_cnt <= '0;
          if (s_in) stuff_viol <= 1'b1;
        end else begin
          ub_valid <= 1'b1;
          ub_bit   <= s_in;
          ones_cnt <= s_in ? ones_cnt + 3'd1 : '0;
        end
        if (end_unstuffer) begin
          ub_last  <= 1'b1;
          us_state <= US_IDLE;
        end
      end
    end
  end

  assign pid_next = {rc_hshake[6:0], ub_bit};

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dec_state  <= DEC_IDLE;
      bit_cnt    <= '0;
      rc_hshake  <= '0;
      PID_error  <= 1'b0;
      fw_valid   <= 1'b0;
      fw_bit     <= 1'b0;
      fw_payload <= 1'b0;
      dec_last   <= 1'b0;
    end else begin
      fw_valid <= 1'b0;
      dec_last <= 1'b0;
      if (start_unstuffer) begin
        dec_state <= DEC_PID;
        bit_cnt   <= '0;
        rc_hshake <= '0;
        PID_error <= 1'b0;
      end else begin
        case (dec_state)
          DEC_PID: begin
            if (ub_valid) begin
              rc_hshake <= pid_next;
              bit_cnt   <= bit_cnt + CW'(1);
              if (bit_cnt == CNT_PID_LAST) begin
                PID_error <= (pid_next[7:4] != ~pid_next[3:0]);
                dec_state <= DEC_DATA;
              end
            end
            if (ub_last) begin
              dec_state <= DEC_DONE;
              dec_last  <= 1'b1;
            end
          end
          DEC_DATA: begin
            // Bits beyond payload + CRC are dropped; the count saturates at the packet length.
            if (ub_valid && (bit_cnt < CNT_PKT_END)) begin
              fw_valid   <= 1'b1;
              fw_bit     <= ub_bit;
              fw_payload <= (bit_cnt < CNT_PAY_END);
              bit_cnt    <= bit_cnt + CW'(1);
            end
            if (ub_last) begin
              dec_state <= DEC_DONE;
              dec_last  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      crc      <= '1;
      rc_data  <= '0;
      crc_last <= 1'b0;
    end else begin
      crc_last <= 1'b0;
      if (start_unstuffer) begin
        crc     <= '1;
        rc_data <= '0;
      end else begin
        if (fw_valid) begin
          crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ fw_bit) ? CRC_POLY : 16'h0000);
          if (fw_payload) rc_data <= {rc_data[DATA_BITS-2:0], fw_bit};
        end
        crc_last <= dec_last;
      end
    end
  end

  // Handshake packets carry no CRC; any other length short of a full data packet is an error.
  always_comb begin
    crc_fail = 1'b1;
    if (bit_cnt == CNT_HSHAKE)
      crc_fail = stuff_viol;
    else if (bit_cnt == CNT_PKT_END)
      crc_fail = (crc != CRC_RESIDUE) | stuff_viol;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_status  <= 1'b0;
      rc_CRCerror <= 1'b0;
    end else if (start_unstuffer) begin
      pkt_status  <= 1'b0;
      rc_CRCerror <= 1'b0;
    end else if (crc_last) begin
      pkt_status  <= 1'b1;
      rc_CRCerror <= crc_fail;
    end else if (pkt_rec) begin
      pkt_status  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_rx_unstuff_crc.sv
// Randomized bench for usb_rx_unstuff_crc: packets are built, stuffed and driven serially,
// and every received packet is compared against a queue-based reference of the receive rules.
module tb_usb_rx_unstuff_crc;

  typedef bit bitq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;  // active-high despite the name
  logic        s_in = 1'b0;
  logic        start_unstuffer = 1'b0;
  logic        end_unstuffer = 1'b0;
  logic        pkt_rec = 1'b0;
  logic        pkt_status;
  logic [7:0]  rc_hshake;
  logic [63:0] rc_data;
  logic        PID_error;
  logic        rc_CRCerror;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  usb_rx_unstuff_crc #(.DATA_BITS(64), .CRC_RESIDUE(16'h800D)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_unstuffer(start_unstuffer),
    .end_unstuffer(end_unstuffer), .pkt_rec(pkt_rec), .pkt_status(pkt_status),
    .rc_hshake(rc_hshake), .rc_data(rc_data), .PID_error(PID_error), .rc_CRCerror(rc_CRCerror)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bitq_t q);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (q[i]) r = (r[15] ^ q[i]) ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  function automatic bitq_t from_str(input string s);
    bitq_t q;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1") q.push_back(1'b1);
      else if (s[i] == "0") q.push_back(1'b0);
    end
    return q;
  endfunction

  // PID bits go out as-is; from the payload on, a 0 follows every run of six 1s.
  function automatic bitq_t stuff(input bitq_t l);
    bitq_t w;
    int ones;
    ones = 0;
    foreach (l[i]) begin
      w.push_back(l[i]);
      if (i >= 8) begin
        ones = l[i] ? ones + 1 : 0;
        if (ones == 6) begin
          w.push_back(1'b0);
          ones = 0;
        end
      end
    end
    return w;
  endfunction

  function automatic bitq_t data_pkt(input logic [7:0] pid, input logic [63:0] pay);
    bitq_t q, p;
    logic [15:0] c;
    for (int i = 7; i >= 0; i--) q.push_back(pid[i]);
    for (int i = 63; i >= 0; i--) begin
      q.push_back(pay[i]);
      p.push_back(pay[i]);
    end
    c = ~crc16(p);
    for (int i = 15; i >= 0; i--) q.push_back(c[i]);
    return q;
  endfunction

  function automatic bitq_t byte_pkt(input logic [7:0] pid);
    bitq_t q;
    for (int i = 7; i >= 0; i--) q.push_back(pid[i]);
    return q;
  endfunction

  // Reference: unstuff the wire bits, then read PID, payload and CRC field from the result.
  task automatic model(input bitq_t w, output logic [7:0] hs, output logic [63:0] data,
                       output logic pe, output logic ce);
    bitq_t d, pay;
    int ones;
    bit viol;
    logic [15:0] rx;
    ones = 0; viol = 0; hs = '0; data = '0; pe = 1'b0; rx = '0;
    foreach (w[i]) begin
      if (i < 8) d.push_back(w[i]);
      else if (ones == 6) begin
        ones = 0;
        if (w[i]) viol = 1;
      end else begin
        d.push_back(w[i]);
        ones = w[i] ? ones + 1 : 0;
      end
    end
    for (int i = 0; i < d.size() && i < 8; i++) hs = {hs[6:0], d[i]};
    if (d.size() >= 8) pe = (hs[7:4] != ~hs[3:0]);
    for (int i = 8; i < d.size() && i < 72; i++) begin
      data = {data[62:0], d[i]};
      pay.push_back(d[i]);
    end
    if (d.size() == 8) ce = viol;
    else if (d.size() < 88) ce = 1'b1;
    else begin
      for (int i = 72; i < 88; i++) rx = {rx[14:0], d[i]};
      ce = viol | (rx != ~crc16(pay));
    end
  endtask

  task automatic drive(input bitq_t w, input int n, input bit close);
    @(negedge clk);
    start_unstuffer = 1'b1;
    s_in = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_unstuffer = 1'b0;
      s_in = w[i];
      end_unstuffer = close && (i == n - 1);
    end
    @(negedge clk);
    end_unstuffer = 1'b0;
    s_in = 1'($urandom);
  endtask

  task automatic run_pkt(input string tag, input bitq_t w);
    logic [7:0] hs;
    logic [63:0] dat;
    logic pe, ce;
    int lat;
    model(w, hs, dat, pe, ce);
    drive(w, w.size(), 1'b1);
    lat = 1;
    while (pkt_status !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd4);
    check({tag, ".status"}, pkt_status, 1'b1);
    check({tag, ".hshake"}, rc_hshake, hs);
    check({tag, ".data"}, rc_data, dat);
    check({tag, ".pid_err"}, PID_error, pe);
    check({tag, ".crc_err"}, rc_CRCerror, ce);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".status"}, pkt_status, 1'b0);
    check({tag, ".hshake"}, rc_hshake, 8'h00);
    check({tag, ".data"}, rc_data, 64'h0);
    check({tag, ".pid_err"}, PID_error, 1'b0);
    check({tag, ".crc_err"}, rc_CRCerror, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bitq_t l, w;
    int ones;
    logic [7:0] pid;
    logic [3:0] nib;
    logic [63:0] pay;
    int kind, len, idx;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b0;

    w = from_str("11000011 1111011101111101101101010111101101111101010111010111111 0 1010100111101101111000101");
    run_pkt("vec", w);
    check("vec.hshake_k", rc_hshake, 8'hC3);
    check("vec.data_k", rc_data, 64'hF77DB57B7D5D7F53);
    check("vec.pid_err_k", PID_error, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.status", pkt_status, 1'b1);
    end
    pkt_rec = 1'b1;
    @(negedge clk);
    pkt_rec = 1'b0;
    check("ack.status", pkt_status, 1'b0);
    check("ack.hshake_held", rc_hshake, 8'hC3);
    pkt_rec = 1'b1;
    @(negedge clk);
    pkt_rec = 1'b0;
    check("ack_idle.status", pkt_status, 1'b0);

    l = data_pkt(8'hC3, 64'hF77DB57B7D5D7F53);
    run_pkt("good", stuff(l));
    check("good.crc_err_k", rc_CRCerror, 1'b0);

    l[8 + 17] = ~l[8 + 17];
    run_pkt("flip", stuff(l));
    check("flip.crc_err_k", rc_CRCerror, 1'b1);

    run_pkt("badpid", stuff(data_pkt(8'b11000010, {$urandom, $urandom})));
    check("badpid.pid_err_k", PID_error, 1'b1);

    run_pkt("hshake", stuff(byte_pkt(8'hD2)));
    check("hshake.status_k", pkt_status, 1'b1);
    check("hshake.crc_err_k", rc_CRCerror, 1'b0);
    check("hshake.data_k", rc_data, 64'h0);

    w = stuff(data_pkt(8'hC3, 64'h00FF00FF_12345678));
    ones = 0;
    for (int i = 8; i < w.size(); i++) begin
      if (ones == 6) begin
        w[i] = 1'b1;
        break;
      end
      ones = w[i] ? ones + 1 : 0;
    end
    run_pkt("seven1s", w);
    check("seven1s.crc_err_k", rc_CRCerror, 1'b1);

    l = from_str("11000011 00000000111111");
    w = stuff(l);
    check("endstuff.wire_len", 64'(w.size()), 64'd23);
    run_pkt("endstuff", w);
    check("endstuff.data_k", rc_data, 64'h3F);

    w = stuff(data_pkt(8'h4B, {$urandom, $urandom}));
    drive(w, 45, 1'b0);
    run_pkt("abort", stuff(data_pkt(8'h5A, {$urandom, $urandom})));

    pkt_rec = 1'b1;
    @(negedge clk);
    pkt_rec = 1'b0;
    end_unstuffer = 1'b1;
    @(negedge clk);
    end_unstuffer = 1'b0;
    repeat (6) @(negedge clk);
    check("nostart.status", pkt_status, 1'b0);

    w = stuff(data_pkt(8'hC3, {$urandom, $urandom}));
    drive(w, 40, 1'b0);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b0;
    run_pkt("postrst", stuff(data_pkt(8'h69, {$urandom, $urandom})));

    for (int it = 0; it < 30; it++) begin
      nib = 4'($urandom);
      pid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {nib, ~nib};
      pay = {$urandom, $urandom} | {$urandom, $urandom};
      kind = int'($urandom_range(0, 6));
      if (kind == 0) l = byte_pkt(pid);
      else l = data_pkt(pid, pay);
      if (kind == 1) begin
        len = int'($urandom_range(9, 87));
        while (l.size() > len) void'(l.pop_back());
      end else if (kind == 2) begin
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++) l.push_back(1'($urandom));
      end else if (kind == 3) begin
        idx = int'($urandom_range(8, 87));
        l[idx] = ~l[idx];
      end
      w = stuff(l);
      if (kind == 4) begin
        idx = int'($urandom_range(0, w.size() - 1));
        w[idx] = ~w[idx];
      end
      run_pkt($sformatf("rand%0d", it), w);
      if ($urandom_range(0, 1) == 1) begin
        pkt_rec = 1'b1;
        @(negedge clk);
        pkt_rec = 1'b0;
        check($sformatf("rand%0d.ack", it), pkt_status, 1'b0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
